// File: rtl/addsub_nibble_sequencer.sv
// Multi-cycle add/subtract: one 4-bit slice per cycle, LSB nibble first,
// with a registered carry between nibbles; done pulses with result, cout and ovf.
module addsub_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            sub_q;
  logic            carry;
  logic [IW-1:0]   idx;

  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [3:0]      sum_nib;
  logic            carry_nxt;
  logic            last;
  logic            ovf_nxt;

  // Handshake: start is accepted on a rising edge only when busy==0 (IDLE or
  // DONE); busy stays high while nibbles run; done is a one-cycle pulse and
  // result/cout/ovf hold from then until the next accepted start.

  // Subtraction is A + ~B + 1: the slice inverts B and the carry is seeded with sub.
  always_comb begin
    a_nib     = a_q[int'(idx)*4 +: 4];
    b_nib     = b_q[int'(idx)*4 +: 4] ^ {4{sub_q}};
    {carry_nxt, sum_nib} = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    last      = (idx == IW'(NIBBLES - 1));
    ovf_nxt   = (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (sum_nib[3] != a_q[W-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            sub_q  <= sub;
            carry  <= sub;
            idx    <= '0;
            result <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          result[int'(idx)*4 +: 4] <= sum_nib;
          carry <= carry_nxt;
          idx   <= idx + 1'b1;
          if (last) begin
            // Final nibble carries the sign bit, so cout/ovf are captured here.
            cout  <= carry_nxt;
            ovf   <= ovf_nxt;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_nibble_sequencer.sv
// Directed bench for addsub_nibble_sequencer (NIBBLES=4, W=16): latency,
// arithmetic corners, ignored start, mid-run reset and back-to-back operation.
module tb_addsub_nibble_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  // expected {ovf, cout, result}
  logic [W+1:0] exp_q[$];

  addsub_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: all called at a negedge
  task automatic drive_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                          input logic [W-1:0] er, input logic ec, input logic eo);
    a     = av;
    b     = bv;
    sub   = sv;
    start = 1'b1;
    exp_q.push_back({eo, ec, er});
  endtask

  // Counts rising edges from the negedge where start was driven until done is seen.
  task automatic wait_done(input int lat0, output int lat, output bit seen);
    lat  = lat0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
      if (done) seen = 1'b1;
    end
  endtask

  // scoreboard
  task automatic score(input string tag);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, 32'(result), 32'(e[W-1:0]));
      check({tag, "_cout"},   32'(cout),   32'(e[W]));
      check({tag, "_ovf"},    32'(ovf),    32'(e[W+1]));
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv, input logic [W-1:0] er, input logic ec, input logic eo);
    int lat;
    bit seen;
    drive_op(av, bv, sv, er, ec, eo);
    wait_done(0, lat, seen);
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd5);
    score(tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(result), 32'(er));
  endtask

  initial begin
    int  lat;
    bit  seen;
    int  pulses;

    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout",   32'(cout),   32'd0);
    check("rst_ovf",    32'(ovf),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add",     16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_op("borrow",  16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("wrap",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub_eq",  16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b0);

    // start pulsed during RUN with different operands must be ignored
    drive_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 16'h0F0F; b = 16'hF0F0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        pulses++;
        score("ign");
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("ign_pulses", 32'(pulses), 32'd1);
    check("ign_hold",   32'(result), 32'h3333);

    // reset in the second RUN cycle aborts with no done pulse
    drive_op(16'h4444, 16'h1111, 1'b0, 16'h5555, 1'b0, 1'b0);
    void'(exp_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy",   32'(busy),   32'd0);
    check("mrst_done",   32'(done),   32'd0);
    check("mrst_result", 32'(result), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) pulses++;
    end
    check("mrst_no_done", 32'(pulses), 32'd0);

    // back-to-back: start held in the DONE cycle
    drive_op(16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0);
    wait_done(0, lat, seen);
    check("b2b1_seen", 32'(seen), 32'd1);
    score("b2b1");
    drive_op(16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done", 32'(done), 32'd0);
    wait_done(1, lat, seen);
    check("b2b2_seen",    32'(seen), 32'd1);
    check("b2b2_latency", 32'(lat),  32'd5);
    score("b2b2");
    @(negedge clk);
    check("b2b2_done_pulse", 32'(done), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
